// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer fed by a TX FIFO with a synchronous
// (BRAM-style) read port.
//
// Each frame: pop one word from the FIFO, wait one cycle (FETCH) for the
// read data, then shift out a start bit, DATA_WIDTH data bits LSB first, an
// optional parity bit and STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT
// clocks.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   tx_en_i      1 = start new frames; 0 = finish current frame, then idle
//   fifo_empty_i FIFO empty flag (looked at only while idle)
//   fifo_data_i  FIFO read data, valid the cycle after fifo_pop_o
//   fifo_pop_o   one-cycle pop strobe (combinational)
//   tx_o         registered serial line, idle high
//   busy_o       registered; high from the cycle after the pop until the
//                last stop bit ends
//
// FIFO handshake: fifo_pop_o is a request that the FIFO always honours
// because it is only raised while fifo_empty_i is low. The popped word is
// expected on fifo_data_i in the following cycle and is captured there.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_nx;
  logic [BAUD_W-1:0]     baud_cnt, baud_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
  logic                  parity_bit, parity_nx;
  logic                  tx_nx, busy_nx;
  logic                  bit_done;

  assign bit_done = (baud_cnt == BAUD_LAST);

  // Gated by reset so no pop can leak out while the block is held in reset.
  assign fifo_pop_o = (state == S_IDLE) & tx_en_i & ~fifo_empty_i & ~rst_i;

  always_comb begin
    state_nx  = state;
    baud_nx   = baud_cnt;
    bit_nx    = bit_cnt;
    shift_nx  = shift_reg;
    parity_nx = parity_bit;

    case (state)
      S_IDLE: begin
        baud_nx = '0;
        bit_nx  = '0;
        if (fifo_pop_o) state_nx = S_FETCH;
      end
      S_FETCH: begin
        shift_nx  = fifo_data_i;
        parity_nx = (^fifo_data_i) ^ (PARITY_ODD != 0);
        baud_nx   = '0;
        state_nx  = S_START;
      end
      S_START: begin
        baud_nx = bit_done ? '0 : baud_cnt + 1'b1;
        if (bit_done) begin
          bit_nx   = '0;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        baud_nx = bit_done ? '0 : baud_cnt + 1'b1;
        if (bit_done) begin
          shift_nx = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nx   = '0;
            state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        baud_nx = bit_done ? '0 : baud_cnt + 1'b1;
        if (bit_done) begin
          bit_nx   = '0;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        baud_nx = bit_done ? '0 : baud_cnt + 1'b1;
        // bit_cnt is reused to count stop bits.
        if (bit_done) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Line level and busy are derived from the next state so that the
    // registered outputs line up with the state they belong to.
    tx_nx = 1'b1;
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
      S_PARITY: tx_nx = parity_nx;
      default:  tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_nx;
      bit_cnt    <= bit_nx;
      shift_reg  <= shift_nx;
      parity_bit <= parity_nx;
      tx_o       <= tx_nx;
      busy_o     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8.
// Four instances cover the configurations: 0 = no parity/1 stop,
// 1 = even parity, 2 = odd parity, 3 = no parity/2 stop bits.
// Each cycle's {fifo_pop_o, busy_o, tx_o} is recorded and compared with a
// trace built from the frame format (bit list, each bit held 4 clocks).
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tx_en = '0;
  logic [3:0] empty = '1;
  logic [7:0] data [4];
  wire  [3:0] pop, tx, busy;

  int vectors = 0;
  int miscompares = 0;

  int pe_of[4]  = '{0, 1, 1, 0};
  int odd_of[4] = '{0, 0, 1, 0};
  int sb_of[4]  = '{1, 1, 1, 2};

  logic [7:0] fifo_q[$];
  logic [2:0] exp_q[$];   // {pop, busy, tx} per cycle
  logic [2:0] obs_q[$];
  int   cur = 0;
  logic pop_d = 1'b0;
  logic en_req = 1'b0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en[0]), .fifo_empty_i(empty[0]),
    .fifo_data_i(data[0]), .fifo_pop_o(pop[0]), .tx_o(tx[0]), .busy_o(busy[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en[1]), .fifo_empty_i(empty[1]),
    .fifo_data_i(data[1]), .fifo_pop_o(pop[1]), .tx_o(tx[1]), .busy_o(busy[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en[2]), .fifo_empty_i(empty[2]),
    .fifo_data_i(data[2]), .fifo_pop_o(pop[2]), .tx_o(tx[2]), .busy_o(busy[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en[3]), .fifo_empty_i(empty[3]),
    .fifo_data_i(data[3]), .fifo_pop_o(pop[3]), .tx_o(tx[3]), .busy_o(busy[3]));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void push_idle(input int n);
    repeat (n) exp_q.push_back(3'b001);
  endfunction

  function automatic void push_frame(input logic [7:0] d, input int pe, input int odd, input int sb);
    int bits[$];
    int ones = 0;
    exp_q.push_back(3'b101);  // pop cycle: line idle, not yet busy
    exp_q.push_back(3'b011);  // read-data cycle: busy, line still high
    bits.push_back(0);
    for (int i = 0; i < 8; i++) begin
      int b;
      b = (int'(d) >> i) & 1;
      bits.push_back(b);
      ones += b;
    end
    if (pe != 0) bits.push_back((ones + odd) % 2);
    repeat (sb) bits.push_back(1);
    foreach (bits[k]) repeat (CPB) exp_q.push_back({1'b0, 1'b1, 1'(bits[k])});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic setup(input int idx);
    tx_en  = '0;
    empty  = '1;
    cur    = idx;
    pop_d  = 1'b0;
    en_req = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // One clock: apply inputs just after the edge, sample mid-cycle. The FIFO
  // model hands out the popped word in the cycle after the pop and random
  // junk otherwise.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (pop_d && fifo_q.size() > 0) data[cur] = fifo_q.pop_front();
    else data[cur] = 8'($urandom);
    empty[cur] = (fifo_q.size() == 0);
    tx_en[cur] = en_req;
    #1;
    obs_q.push_back({pop[cur], busy[cur], tx[cur]});
    pop_d = pop[cur];
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #2;
      tx_en = 4'($urandom);
      empty = 4'($urandom);
      for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
      #1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if ({pop[i], busy[i], tx[i]} !== 3'b001) begin
          miscompares++;
          $display("FAIL reset_hold dut%0d: pop/busy/tx=%b expected 001", i, {pop[i], busy[i], tx[i]});
        end
      end
    end
    tx_en = '0;
    empty = '1;
    @(negedge clk);
    rst = 1'b0;

    // Abort mid-DATA while the line is low (byte 0x00).
    setup(0);
    fifo_q.push_back(8'h00);
    en_req = 1'b1;
    run(8);
    en_req = 1'b0;
    tx_en[0] = 1'b0;
    vectors++;
    if (tx[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_data_low: tx=%b expected 0", tx[0]);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({pop[0], busy[0], tx[0]} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_async: pop/busy/tx=%b expected 001", {pop[0], busy[0], tx[0]});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({pop[0], busy[0], tx[0]} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_async_hold: pop/busy/tx=%b expected 001", {pop[0], busy[0], tx[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    setup(0);
  endtask

  task automatic test_basic_frame();
    int nb = 0;
    setup(0);
    fifo_q.push_back(8'hA5);
    en_req = 1'b1;
    push_frame(8'hA5, 0, 0, 1);
    push_idle(3);
    run(exp_q.size());
    en_req = 1'b0;
    foreach (exp_q[k]) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL basic_frame cycle %0d: pop/busy/tx=%b expected %b", k, obs_q[k], exp_q[k]);
      end
    end
    foreach (obs_q[k]) if (obs_q[k][1] === 1'b1) nb++;
    vectors++;
    if (nb != 41) begin
      miscompares++;
      $display("FAIL basic_busy_len: busy cycles=%0d expected 41", nb);
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    logic [7:0] dec[$];
    int k = 0;
    int npop = 0;
    setup(0);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    en_req = 1'b1;
    push_frame(8'h00, 0, 0, 1);
    push_frame(8'hFF, 0, 0, 1);
    push_idle(3);
    run(exp_q.size());
    en_req = 1'b0;
    foreach (exp_q[j]) begin
      vectors++;
      if (obs_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL b2b_trace cycle %0d: pop/busy/tx=%b expected %b", j, obs_q[j], exp_q[j]);
      end
    end
    foreach (obs_q[j]) if (obs_q[j][2] === 1'b1) npop++;
    vectors++;
    if (npop != 2) begin
      miscompares++;
      $display("FAIL b2b_pops: pops=%0d expected 2", npop);
    end
    // Independent line decode: sample each bit in its middle.
    while (k + 40 <= obs_q.size()) begin
      logic [7:0] b;
      if (obs_q[k][0] === 1'b0) begin
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = obs_q[k + CPB + CPB * i + 2][0];
        starts.push_back(k);
        dec.push_back(b);
        k += 40;
      end else begin
        k++;
      end
    end
    vectors++;
    if (dec.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_decode_count: frames=%0d expected 2", dec.size());
    end else begin
      vectors++;
      if (dec[0] !== 8'h00) begin
        miscompares++;
        $display("FAIL b2b_byte0: got %h expected 00", dec[0]);
      end
      vectors++;
      if (dec[1] !== 8'hFF) begin
        miscompares++;
        $display("FAIL b2b_byte1: got %h expected ff", dec[1]);
      end
      vectors++;
      if (starts[1] - starts[0] != 42) begin
        miscompares++;
        $display("FAIL b2b_gap: start spacing=%0d expected 42", starts[1] - starts[0]);
      end
    end
  endtask

  task automatic test_parity();
    for (int inst = 1; inst <= 2; inst++) begin
      int nb = 0;
      logic exp_par;
      exp_par = (inst == 1) ? 1'b1 : 1'b0;
      setup(inst);
      fifo_q.push_back(8'h07);
      en_req = 1'b1;
      push_frame(8'h07, pe_of[inst], odd_of[inst], sb_of[inst]);
      push_idle(3);
      run(exp_q.size());
      en_req = 1'b0;
      foreach (exp_q[k]) begin
        vectors++;
        if (obs_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL parity_trace dut%0d cycle %0d: pop/busy/tx=%b expected %b", inst, k, obs_q[k], exp_q[k]);
        end
      end
      vectors++;
      if (obs_q[2 + 9 * CPB + 2][0] !== exp_par) begin
        miscompares++;
        $display("FAIL parity_bit dut%0d: got %b expected %b", inst, obs_q[2 + 9 * CPB + 2][0], exp_par);
      end
      foreach (obs_q[k]) if (obs_q[k][1] === 1'b1) nb++;
      vectors++;
      if (nb != 45) begin
        miscompares++;
        $display("FAIL parity_len dut%0d: busy cycles=%0d expected 45", inst, nb);
      end
    end
  endtask

  task automatic test_stop2_enable();
    setup(3);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h81);
    push_frame(8'h3C, 0, 0, 2);
    push_idle(20);
    push_frame(8'h81, 0, 0, 2);
    push_idle(3);
    en_req = 1'b1;
    run(12);          // into the data bits
    en_req = 1'b0;
    run(34 + 20);     // rest of frame, then held idle with data waiting
    en_req = 1'b1;
    run(46 + 3);
    en_req = 1'b0;
    foreach (exp_q[k]) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL stop2_enable cycle %0d: pop/busy/tx=%b expected %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_empty();
    setup(0);
    en_req = 1'b1;
    push_idle(50);
    run(50);
    en_req = 1'b0;
    foreach (exp_q[k]) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL empty_idle cycle %0d: pop/busy/tx=%b expected %b", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    repeat (4) begin
      int inst;
      int n;
      inst = $urandom_range(0, 3);
      n = $urandom_range(2, 4);
      setup(inst);
      repeat (n) begin
        logic [7:0] b;
        b = 8'($urandom);
        fifo_q.push_back(b);
        push_frame(b, pe_of[inst], odd_of[inst], sb_of[inst]);
      end
      push_idle(3);
      en_req = 1'b1;
      run(exp_q.size());
      en_req = 1'b0;
      foreach (exp_q[k]) begin
        vectors++;
        if (obs_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL random dut%0d cycle %0d: pop/busy/tx=%b expected %b", inst, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 4; i++) data[i] = '0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_parity();
    test_stop2_enable();
    test_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
